// File: rtl/hilo_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_ctrl
//
// Iterative multiply/divide sequencer that owns the architectural HI/LO
// registers of the Mini-MIPS core. Decode issues MULT/MULTU/MADD/MADDU/
// DIV/DIVU/MTHI/MTLO through a start/ready handshake. The pipeline stalls
// while busy is high. Multiplies use shift-add and divides use restoring
// division, each one bit per cycle.
//
// Optional feature macro: HILO_DIV_EN
//   defined   : the divider datapath is built and DIV/DIVU run for XLEN cycles.
//   undefined : there is no divider. DIV/DIVU finish immediately with hi/lo
//               unchanged and dbz=1, which flags an unsupported op.
//
// Parameters:
//   XLEN      operand width. HI and LO are XLEN bits each. The iteration
//             count is XLEN.
//   RST_HILO  value loaded into hi and lo on reset.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset; aborts any operation in flight
//   start  in   request, accepted when start && ready
//   op     in   000 MULT, 001 MULTU, 010 MADD, 011 MADDU,
//               100 DIV, 101 DIVU, 110 MTHI, 111 MTLO
//   rs     in   operand A / dividend / MTHI-MTLO source
//   rt     in   operand B / divisor
//   ready  out  high only in IDLE
//   busy   out  high while iterating (MUL or DIV)
//   done   out  one-cycle pulse when hi/lo hold the result
//   dbz    out  valid with done; divide-by-zero (or unsupported divide)
//   hi     out  HI register
//   lo     out  LO register
// -----------------------------------------------------------------------------
module hilo_muldiv_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RST_HILO = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic            dbz,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int            CW   = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MADDU = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIN
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  // Shared working register.
  // MUL: {partial product high, multiplier shifting out at the bottom}.
  // DIV: {partial remainder, dividend shifting into the quotient}.
  logic [2*XLEN-1:0] work;
  // Multiplicand magnitude (MUL) or divisor magnitude (DIV).
  logic [XLEN-1:0]   mcand;
  logic              neg_res;
  logic              acc_en;

  // Operand conditioning at accept time. Odd opcodes are the unsigned forms.
  logic            signed_op;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;

  assign signed_op = ~op[0];
  assign sign_a    = signed_op & rs[XLEN-1];
  assign sign_b    = signed_op & rt[XLEN-1];
  assign mag_a     = sign_a ? -rs : rs;
  assign mag_b     = sign_b ? -rt : rt;

  // One shift-add step. The final step feeds the sign fix and the MADD
  // accumulate directly, so hi/lo load on the same edge that enters FIN.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] mul_prod;
  logic [2*XLEN-1:0] mul_result;

  assign mul_sum    = {1'b0, work[2*XLEN-1:XLEN]} + {1'b0, (work[0] ? mcand : {XLEN{1'b0}})};
  assign mul_next   = {mul_sum, work[XLEN-1:1]};
  assign mul_prod   = neg_res ? -mul_next : mul_next;
  assign mul_result = acc_en ? ({hi, lo} + mul_prod) : mul_prod;

`ifdef HILO_DIV_EN
  logic            neg_rem;
  logic            div_zero;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_rem_nx;
  logic [XLEN-1:0] div_quo_nx;
  logic [XLEN-1:0] div_hi;
  logic [XLEN-1:0] div_lo;

  // Restoring step. The partial remainder is always below the divisor, so
  // the difference fits in XLEN bits whenever the subtraction is taken.
  // A zero divisor makes every step subtract nothing. The remainder then
  // collects the dividend bits, so the sign fix below returns rs on hi.
  assign div_shift  = {work[2*XLEN-1:XLEN], work[XLEN-1]};
  assign div_ge     = div_shift >= {1'b0, mcand};
  assign div_rem_nx = div_ge ? (div_shift[XLEN-1:0] - mcand) : div_shift[XLEN-1:0];
  assign div_quo_nx = {work[XLEN-2:0], div_ge};
  assign div_lo     = div_zero ? {XLEN{1'b1}} : (neg_res ? -div_quo_nx : div_quo_nx);
  assign div_hi     = neg_rem ? -div_rem_nx : div_rem_nx;
`endif

  // Control FSM with registered handshake outputs. hi/lo change only on
  // MTHI/MTLO accept or on the edge that enters FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      dbz      <= 1'b0;
      hi       <= RST_HILO;
      lo       <= RST_HILO;
      cnt      <= '0;
      work     <= '0;
      mcand    <= '0;
      neg_res  <= 1'b0;
      acc_en   <= 1'b0;
`ifdef HILO_DIV_EN
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt <= '0;
            case (op)
              OP_MTHI: begin
                hi    <= rs;
                state <= S_FIN;
                ready <= 1'b0;
                done  <= 1'b1;
                dbz   <= 1'b0;
              end
              OP_MTLO: begin
                lo    <= rs;
                state <= S_FIN;
                ready <= 1'b0;
                done  <= 1'b1;
                dbz   <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
`ifdef HILO_DIV_EN
                work     <= {{XLEN{1'b0}}, mag_a};
                mcand    <= mag_b;
                neg_res  <= sign_a ^ sign_b;
                neg_rem  <= sign_a;
                div_zero <= (rt == '0);
                state    <= S_DIV;
                ready    <= 1'b0;
                busy     <= 1'b1;
`else
                state <= S_FIN;
                ready <= 1'b0;
                done  <= 1'b1;
                dbz   <= 1'b1;
`endif
              end
              default: begin
                work    <= {{XLEN{1'b0}}, mag_b};
                mcand   <= mag_a;
                neg_res <= sign_a ^ sign_b;
                acc_en  <= (op == OP_MADD) || (op == OP_MADDU);
                state   <= S_MUL;
                ready   <= 1'b0;
                busy    <= 1'b1;
              end
            endcase
          end
        end

        S_MUL: begin
          work <= mul_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            {hi, lo} <= mul_result;
            cnt      <= '0;
            state    <= S_FIN;
            busy     <= 1'b0;
            done     <= 1'b1;
            dbz      <= 1'b0;
          end
        end

`ifdef HILO_DIV_EN
        S_DIV: begin
          work <= {div_rem_nx, div_quo_nx};
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            hi    <= div_hi;
            lo    <= div_lo;
            cnt   <= '0;
            state <= S_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            dbz   <= div_zero;
          end
        end
`endif

        S_FIN: begin
          state <= S_IDLE;
          ready <= 1'b1;
          done  <= 1'b0;
          dbz   <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
          dbz   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_muldiv_ctrl
//
// Self-checking bench for hilo_muldiv_ctrl with XLEN=32 and RST_HILO=0.
// A table of {op, rs, rt, expected hi/lo/dbz/latency} rows runs in order,
// so each row's expected hi/lo follows from the rows before it. Expected
// values for DIV/DIVU depend on whether HILO_DIV_EN is defined. Hand-written
// sequences cover the following cases:
//   - start ignored while busy,
//   - start ignored in FIN,
//   - reset aborting an operation in flight.
// -----------------------------------------------------------------------------
module tb_hilo_muldiv_ctrl;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MADDU = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;
  localparam int         NVEC     = 16;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
    int          exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        ready;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [31:0] hi;
  logic [31:0] lo;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  hilo_muldiv_ctrl #(.XLEN(32), .RST_HILO(32'h0)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz),
    .hi    (hi),
    .lo    (lo)
  );

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Issue one op, then follow it cycle by cycle until done. Operands are
  // scrambled right after the accept edge, so the result must come from
  // the latched values.
  task automatic applyStimulus(input vec_t v, input string tag);
    int          cyc;
    int          wait_n;
    int          busy_n;
    bit          ready_low;
    bit          stable;
    logic [31:0] hi0;
    logic [31:0] lo0;
    wait_n = 0;
    while (!ready && wait_n < 50) begin
      step();
      wait_n++;
    end
    checkOutput({tag, " ready_before"}, 64'(ready), 64'd1);
    hi0   = hi;
    lo0   = lo;
    op    = v.op;
    rs    = v.rs;
    rt    = v.rt;
    start = 1'b1;
    step();
    start     = 1'b0;
    rs        = $urandom;
    rt        = $urandom;
    op        = 3'($urandom);
    cyc       = 1;
    busy_n    = 0;
    ready_low = 1'b1;
    stable    = 1'b1;
    while (!done && cyc < 40) begin
      if (busy) busy_n++;
      if (ready) ready_low = 1'b0;
      if (hi !== hi0 || lo !== lo0) stable = 1'b0;
      step();
      cyc++;
    end
    checkOutput({tag, " latency"}, 64'(done ? cyc : -1), 64'(v.exp_lat));
    checkOutput({tag, " hi"}, 64'(hi), 64'(v.exp_hi));
    checkOutput({tag, " lo"}, 64'(lo), 64'(v.exp_lo));
    checkOutput({tag, " dbz"}, 64'(dbz), 64'(v.exp_dbz));
    checkOutput({tag, " busy_cycles"}, 64'(busy_n), 64'(v.exp_lat - 1));
    checkOutput({tag, " ready_low_while_busy"}, 64'(ready_low), 64'd1);
    checkOutput({tag, " hilo_stable"}, 64'(stable), 64'd1);
    step();
    checkOutput({tag, " ready_done_after"}, 64'({ready, done}), 64'(2'b10));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   cyc;
    int   done_n;
    vec_t v;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
    vecs[2]  = '{OP_MTLO,  32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000005, 1'b0, 1};
    vecs[3]  = '{OP_MTHI,  32'h00000000, 32'h00000000, 32'h00000000, 32'h00000005, 1'b0, 1};
    vecs[4]  = '{OP_MADD,  32'h00000002, 32'h00000003, 32'h00000000, 32'h0000000B, 1'b0, 33};
    vecs[5]  = '{OP_MADDU, 32'hFFFFFFFF, 32'h00000002, 32'h00000002, 32'h00000009, 1'b0, 33};
`ifdef HILO_DIV_EN
    vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[7]  = '{OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 33};
    vecs[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    vecs[9]  = '{OP_MTHI,  32'h00000001, 32'h00000000, 32'h00000001, 32'h80000000, 1'b0, 1};
`else
    vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h00000002, 32'h00000009, 1'b1, 1};
    vecs[7]  = '{OP_DIVU,  32'h00001234, 32'h00000000, 32'h00000002, 32'h00000009, 1'b1, 1};
    vecs[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000002, 32'h00000009, 1'b1, 1};
    vecs[9]  = '{OP_MTHI,  32'h00000001, 32'h00000000, 32'h00000001, 32'h00000009, 1'b0, 1};
`endif
    vecs[10] = '{OP_MTLO,  32'h00000000, 32'h00000000, 32'h00000001, 32'h00000000, 1'b0, 1};
    vecs[11] = '{OP_MADD,  32'hFFFFFFFF, 32'h00000003, 32'h00000000, 32'hFFFFFFFD, 1'b0, 33};
`ifdef HILO_DIV_EN
    vecs[12] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
    vecs[13] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 33};
`else
    vecs[12] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFD, 1'b1, 1};
    vecs[13] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h00000000, 32'hFFFFFFFD, 1'b1, 1};
`endif
    vecs[14] = '{OP_MULTU, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    vecs[15] = '{OP_MULT,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33};

    rst   = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    rs    = 32'h0;
    rt    = 32'h0;
    repeat (3) step();
    rst = 1'b0;
    checkOutput("reset ready", 64'(ready), 64'd1);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done_dbz", 64'({done, dbz}), 64'd0);
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], $sformatf("row%0d", i));
    end

    // MULTU 3*4. A MTHI pulse at cycle 5 must be dropped. A MTLO held from
    // the FIN cycle must be accepted only once the FSM is back in IDLE.
    op    = OP_MULTU;
    rs    = 32'd3;
    rt    = 32'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc   = 1;
    while (cyc < 5) begin
      step();
      cyc++;
    end
    op    = OP_MTHI;
    rs    = 32'hDEADBEEF;
    start = 1'b1;
    step();
    cyc++;
    start = 1'b0;
    while (!done && cyc < 40) begin
      step();
      cyc++;
    end
    checkOutput("ignore_busy latency", 64'(done ? cyc : -1), 64'd33);
    checkOutput("ignore_busy hi", 64'(hi), 64'h0);
    checkOutput("ignore_busy lo", 64'(lo), 64'hC);
    op    = OP_MTLO;
    rs    = 32'h77;
    start = 1'b1;
    step();
    checkOutput("ignore_fin ready_done", 64'({ready, done}), 64'(2'b10));
    step();
    start = 1'b0;
    checkOutput("fin_then_accept done", 64'(done), 64'd1);
    checkOutput("fin_then_accept lo", 64'(lo), 64'h77);
    checkOutput("fin_then_accept hi", 64'(hi), 64'h0);
    step();

    // Preload a nonzero HI, start a MULT, poke start at cycle 5, then reset
    // at cycle 10. The aborted op must never report done.
    v = '{OP_MTHI, 32'h0000ABCD, 32'h0, 32'h0000ABCD, 32'h00000077, 1'b0, 1};
    applyStimulus(v, "preload");
    op    = OP_MULT;
    rs    = 32'd7;
    rt    = 32'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc   = 1;
    while (cyc < 5) begin
      step();
      cyc++;
    end
    op    = OP_MTLO;
    rs    = 32'h1111;
    start = 1'b1;
    step();
    cyc++;
    start = 1'b0;
    while (cyc < 10) begin
      step();
      cyc++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("abort ready", 64'(ready), 64'd1);
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort done", 64'(done), 64'd0);
    checkOutput("abort hi", 64'(hi), 64'h0);
    checkOutput("abort lo", 64'(lo), 64'h0);
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) done_n++;
      step();
    end
    checkOutput("abort no_done", 64'(done_n), 64'd0);
    checkOutput("abort idle_after", 64'({ready, busy}), 64'(2'b10));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
